// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, combinational ROM access and a 2-entry
// fetch queue feeding decode over valid/ready, with redirect and fault handling.
module fetch_unit #(
    parameter logic [63:0] RESET_PC      = 64'h0,
    parameter int unsigned ROM_ADDR_BITS = 14
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] im_addr,
    input  logic [31:0] im_dout,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_inst,
    output logic [1:0]  if_fault,
    input  logic        id_ready
);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [1:0]  fault;
    } entry_t;

    entry_t      queue [2];
    logic [63:0] pc;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        halted;

    logic        pop;
    logic        push;
    entry_t      fetched;

    always_comb begin
        // NOTE: every signal written here gets a value on every path; a missed assignment infers a latch.
        fetched          = '0;
        fetched.pc       = pc;
        fetched.fault[0] = (pc[1:0] != 2'b00);
        fetched.fault[1] = ((pc >> ROM_ADDR_BITS) != 64'h0);
        fetched.inst     = (fetched.fault == 2'b00) ? im_dout : 32'h0;

        pop  = (count != 2'd0) && id_ready;
        push = !halted && ((count != 2'd2) || pop);
    end

    // NOTE: state uses non-blocking assignments only; queue storage is reset too because the head is exposed directly on if_*.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            halted   <= 1'b0;
            queue[0] <= '0;
            queue[1] <= '0;
        end else if (redirect_valid) begin
            // Decode is flushed by the same redirect, so any handshake this cycle is dropped.
            pc     <= redirect_pc;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            halted <= 1'b0;
        end else begin
            if (push) begin
                queue[wr_ptr] <= fetched;
                wr_ptr        <= ~wr_ptr;
                if (fetched.fault != 2'b00) begin
                    halted <= 1'b1;
                end else begin
                    pc <= pc + 64'd4;
                end
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    assign im_addr  = pc;
    assign if_valid = (count != 2'd0);
    assign if_pc    = queue[rd_ptr].pc;
    assign if_inst  = queue[rd_ptr].inst;
    assign if_fault = queue[rd_ptr].fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed test-plan steps followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [63:0] im_addr;
    logic [31:0] im_dout;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic [1:0]  if_fault;
    logic        id_ready;

    fetch_unit #(
        .RESET_PC      (64'h0),
        .ROM_ADDR_BITS (14)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .im_addr        (im_addr),
        .im_dout        (im_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_fault       (if_fault),
        .id_ready       (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16 KiB ROM, word-addressed, answering combinationally.
    logic [31:0] rom [4096];
    assign im_dout = rom[im_addr[13:2]];

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [1:0]  fault;
    } ment_t;

    ment_t       mq [$];
    logic [63:0] m_pc;
    logic        m_halted;
    logic        m_known;
    logic        m_after_rst;

    int n_cmp;
    int n_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare DUT outputs to the model, then advance the model by one clock
    // using the inputs currently applied; returns at the next falling edge.
    task automatic cycle();
        ment_t e;
        logic  pop;
        logic  push;
        if (m_known) begin
            check("if_valid", if_valid, (mq.size() != 0));
            check("im_addr", im_addr, m_pc);
            if (mq.size() != 0) begin
                check("if_pc", if_pc, mq[0].pc);
                check("if_inst", if_inst, mq[0].inst);
                check("if_fault", if_fault, mq[0].fault);
            end else if (m_after_rst) begin
                check("rst_if_pc", if_pc, 64'h0);
                check("rst_if_inst", if_inst, 64'h0);
                check("rst_if_fault", if_fault, 64'h0);
            end
        end
        m_after_rst = 1'b0;
        if (rst) begin
            mq.delete();
            m_pc        = 64'h0;
            m_halted    = 1'b0;
            m_known     = 1'b1;
            m_after_rst = 1'b1;
        end else if (redirect_valid) begin
            mq.delete();
            m_pc     = redirect_pc;
            m_halted = 1'b0;
        end else begin
            pop  = (mq.size() != 0) && id_ready;
            push = !m_halted && (mq.size() < 2 || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.pc       = m_pc;
                e.fault[0] = (m_pc % 4) != 0;
                e.fault[1] = m_pc >= 64'h4000;
                e.inst     = (e.fault == 2'b00) ? rom[m_pc[13:2]] : 32'h0;
                mq.push_back(e);
                if (e.fault != 2'b00) m_halted = 1'b1;
                else m_pc = m_pc + 64'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] words [4];
        int          sel;
        n_cmp       = 0;
        n_err       = 0;
        m_known     = 1'b0;
        m_after_rst = 1'b0;
        m_pc        = 64'h0;
        m_halted    = 1'b0;
        for (int i = 0; i < 4096; i++) rom[i] = $urandom;
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        words[2] = 32'h0020_0113;
        words[3] = 32'h0030_0193;
        for (int i = 0; i < 4; i++) rom[i] = words[i];

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        id_ready       = 1'b1;
        @(negedge clk);
        cycle();
        cycle();

        // Reset release and streaming.
        rst = 1'b0;
        check("rel_valid", if_valid, 64'h0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            check("stream_pc", if_pc, 64'(4 * i));
            check("stream_inst", if_inst, 64'(words[i]));
            check("stream_fault", if_fault, 64'h0);
            cycle();
        end

        // Backpressure.
        id_ready = 1'b0;
        repeat (5) cycle();
        check("bp_count", if_valid, 64'h1);
        check("bp_pc_ahead", im_addr, mq[0].pc + 64'd8);
        id_ready = 1'b1;
        repeat (4) cycle();

        // Redirect on a full queue.
        id_ready = 1'b0;
        repeat (3) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        cycle();
        redirect_valid = 1'b0;
        check("redir_valid", if_valid, 64'h0);
        check("redir_addr", im_addr, 64'h40);
        cycle();
        check("redir_pc", if_pc, 64'h40);
        check("redir_inst", if_inst, 64'(rom[16]));
        id_ready = 1'b1;
        repeat (2) cycle();

        // Misaligned redirect.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h42;
        cycle();
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        cycle();
        check("mis_pc", if_pc, 64'h42);
        check("mis_fault", if_fault, 64'h1);
        check("mis_inst", if_inst, 64'h0);
        id_ready = 1'b1;
        repeat (3) cycle();
        check("mis_hold", im_addr, 64'h42);
        check("mis_empty", if_valid, 64'h0);

        // Out-of-range fetch, then resume at 0.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h4000;
        cycle();
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        cycle();
        check("oor_fault", if_fault, 64'h2);
        check("oor_inst", if_inst, 64'h0);
        id_ready = 1'b1;
        repeat (3) cycle();
        check("oor_hold", im_addr, 64'h4000);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0;
        cycle();
        redirect_valid = 1'b0;
        repeat (4) cycle();

        // Reset mid-stream overriding a redirect.
        id_ready = 1'b0;
        repeat (3) cycle();
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80;
        cycle();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        check("mrst_valid", if_valid, 64'h0);
        check("mrst_pc", if_pc, 64'h0);
        check("mrst_addr", im_addr, 64'h0);
        id_ready = 1'b1;
        cycle();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            id_ready       = ($urandom_range(3) != 0);
            rst            = ($urandom_range(63) == 0);
            redirect_valid = ($urandom_range(15) == 0);
            sel            = $urandom_range(5);
            case (sel)
                0: redirect_pc = 64'($urandom_range(32'h3FF8, 32'h3FE0)) & ~64'h3;
                1: redirect_pc = 64'($urandom_range(32'h3FFF)) | 64'h1;
                2: redirect_pc = {$urandom, $urandom};
                default: redirect_pc = 64'($urandom_range(32'h3FFF)) & ~64'h3;
            endcase
            cycle();
        end
        rst            = 1'b0;
        redirect_valid = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
